// File: rtl/netlist_eval_engine_if.sv
// netlist_eval_engine_if
//   Groups the program, map, run-control and result signals of
//   netlist_eval_engine into one bundle.
//   slave  modport: the engine side (takes program/map/run inputs, drives results).
//   master modport: the host side (drives program/map/run, consumes results).
//   Signals:
//     prog_we/prog_addr/prog_op/prog_src_a/prog_src_b/prog_dst  gate program write
//     map_we/map_idx/map_node                                    output map write
//     num_gates/start/in_vec                                     run request
//     busy/out_valid/out_ready/out_vec/err                       status and result
//   Optional macro EVAL_TRACE_EN adds trace_valid/trace_dst/trace_val.
interface netlist_eval_engine_if #(
  parameter int NUM_IN    = 14,
  parameter int NUM_OUT   = 8,
  parameter int NUM_NODES = 128,
  parameter int MAX_GATES = 96
) ();
  localparam int ADDR_W = $clog2(NUM_NODES);
  localparam int GATE_W = $clog2(MAX_GATES + 1);
  localparam int MAP_W  = $clog2(NUM_OUT);

  logic              prog_we;
  logic [GATE_W-1:0] prog_addr;
  logic [2:0]        prog_op;
  logic [ADDR_W-1:0] prog_src_a;
  logic [ADDR_W-1:0] prog_src_b;
  logic [ADDR_W-1:0] prog_dst;
  logic              map_we;
  logic [MAP_W-1:0]  map_idx;
  logic [ADDR_W-1:0] map_node;
  logic [GATE_W-1:0] num_gates;
  logic              start;
  logic [NUM_IN-1:0] in_vec;
  logic              busy;
  logic              out_valid;
  logic              out_ready;
  logic [NUM_OUT-1:0] out_vec;
  logic              err;
`ifdef EVAL_TRACE_EN
  logic              trace_valid;
  logic [ADDR_W-1:0] trace_dst;
  logic              trace_val;
`endif

  modport slave (
    input  prog_we, prog_addr, prog_op, prog_src_a, prog_src_b, prog_dst,
    input  map_we, map_idx, map_node,
    input  num_gates, start, in_vec, out_ready,
`ifdef EVAL_TRACE_EN
    output trace_valid, trace_dst, trace_val,
`endif
    output busy, out_valid, out_vec, err
  );

  modport master (
    output prog_we, prog_addr, prog_op, prog_src_a, prog_src_b, prog_dst,
    output map_we, map_idx, map_node,
    output num_gates, start, in_vec, out_ready,
`ifdef EVAL_TRACE_EN
    input  trace_valid, trace_dst, trace_val,
`endif
    input  busy, out_valid, out_vec, err
  );
endinterface

// File: rtl/netlist_eval_engine.sv
// netlist_eval_engine
//   Sequential evaluator for small gate-level netlists. A gate list and an
//   output map are written through the program port; each run loads one input
//   vector into the node file and executes one gate per cycle in program order,
//   then presents the mapped outputs with a valid/ready handshake.
//   Ports:
//     clk    clock
//     rst_n  asynchronous active-low reset (clears program memory too)
//     bus    netlist_eval_engine_if.slave (program, map, run, result, err)
//   Optional macro EVAL_TRACE_EN adds a per-gate trace of the node written.
module netlist_eval_engine #(
  parameter int NUM_IN    = 14,
  parameter int NUM_OUT   = 8,
  parameter int NUM_NODES = 128,
  parameter int MAX_GATES = 96
) (
  input  logic clk,
  input  logic rst_n,
  netlist_eval_engine_if.slave bus
);
  localparam int ADDR_W = $clog2(NUM_NODES);
  localparam int GATE_W = $clog2(MAX_GATES + 1);

  typedef enum logic [1:0] {IDLE, LOAD, EVAL, DONE} state_t;

  state_t             state;
  logic [2:0]         g_op    [MAX_GATES];
  logic [ADDR_W-1:0]  g_src_a [MAX_GATES];
  logic [ADDR_W-1:0]  g_src_b [MAX_GATES];
  logic [ADDR_W-1:0]  g_dst   [MAX_GATES];
  logic [ADDR_W-1:0]  out_map [NUM_OUT];
  logic [NUM_NODES-1:0] nodes;
  logic [NUM_NODES-1:0] nodes_next;
  logic [NUM_IN-1:0]  in_lat;
  logic [GATE_W-1:0]  run_gates;
  logic [GATE_W-1:0]  ptr;
  logic [NUM_OUT-1:0] out_gather;
  logic               op_a, op_b, gate_res, dst_bad, gates_over;
  logic [GATE_W-1:0]  eff_gates;
  logic               busy_r, out_valid_r, err_r;
  logic [NUM_OUT-1:0] out_vec_r;

  assign gates_over = bus.num_gates > GATE_W'(MAX_GATES);
  assign eff_gates  = gates_over ? GATE_W'(MAX_GATES) : bus.num_gates;

  // Current gate result and the node file as it will look after this cycle.
  // Outputs are gathered from nodes_next so the last gate's write is visible
  // in the registered out_vec on DONE entry.
  always_comb begin
    op_a     = nodes[g_src_a[ptr]];
    op_b     = nodes[g_src_b[ptr]];
    dst_bad  = g_dst[ptr] < ADDR_W'(NUM_IN);
    gate_res = 1'b0;
    case (g_op[ptr])
      3'd0: gate_res = op_a & op_b;
      3'd1: gate_res = op_a | op_b;
      3'd2: gate_res = ~(op_a & op_b);
      3'd3: gate_res = ~(op_a | op_b);
      3'd4: gate_res = op_a ^ op_b;
      3'd5: gate_res = ~(op_a ^ op_b);
      3'd6: gate_res = ~op_a;
      default: gate_res = op_a;
    endcase
    nodes_next = nodes;
    if (state == LOAD) begin
      nodes_next = NUM_NODES'(in_lat);
    end else if (state == EVAL && !dst_bad) begin
      nodes_next[g_dst[ptr]] = gate_res;
    end
    for (int k = 0; k < NUM_OUT; k++) begin
      out_gather[k] = nodes_next[out_map[k]];
    end
  end

  // Program/map writes, node file and the run FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      busy_r      <= 1'b0;
      out_valid_r <= 1'b0;
      out_vec_r   <= '0;
      err_r       <= 1'b0;
      nodes       <= '0;
      in_lat      <= '0;
      run_gates   <= '0;
      ptr         <= '0;
      for (int i = 0; i < MAX_GATES; i++) begin
        g_op[i]    <= '0;
        g_src_a[i] <= '0;
        g_src_b[i] <= '0;
        g_dst[i]   <= '0;
      end
      for (int k = 0; k < NUM_OUT; k++) begin
        out_map[k] <= '0;
      end
    end else begin
      if (bus.prog_we) begin
        if (state != IDLE) begin
          err_r <= 1'b1;
        end else if (bus.prog_addr < GATE_W'(MAX_GATES)) begin
          g_op[bus.prog_addr]    <= bus.prog_op;
          g_src_a[bus.prog_addr] <= bus.prog_src_a;
          g_src_b[bus.prog_addr] <= bus.prog_src_b;
          g_dst[bus.prog_addr]   <= bus.prog_dst;
        end
      end
      if (bus.map_we) begin
        if (state != IDLE) begin
          err_r <= 1'b1;
        end else begin
          out_map[bus.map_idx] <= bus.map_node;
        end
      end
      nodes <= nodes_next;
      case (state)
        IDLE: begin
          if (bus.start) begin
            in_lat    <= bus.in_vec;
            run_gates <= eff_gates;
            err_r     <= gates_over;
            busy_r    <= 1'b1;
            state     <= LOAD;
          end
        end
        LOAD: begin
          ptr <= '0;
          if (run_gates == '0) begin
            out_vec_r   <= out_gather;
            out_valid_r <= 1'b1;
            state       <= DONE;
          end else begin
            state <= EVAL;
          end
        end
        EVAL: begin
          if (dst_bad) begin
            err_r <= 1'b1;
          end
          ptr <= ptr + GATE_W'(1);
          if (ptr == run_gates - GATE_W'(1)) begin
            out_vec_r   <= out_gather;
            out_valid_r <= 1'b1;
            state       <= DONE;
          end
        end
        default: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            state       <= IDLE;
          end
        end
      endcase
    end
  end

  assign bus.busy      = busy_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_vec   = out_vec_r;
  assign bus.err       = err_r;

`ifdef EVAL_TRACE_EN
  logic              trace_valid_r, trace_val_r;
  logic [ADDR_W-1:0] trace_dst_r;

  // One-cycle-delayed report of each node write; suppressed writes stay invisible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trace_valid_r <= 1'b0;
      trace_dst_r   <= '0;
      trace_val_r   <= 1'b0;
    end else begin
      trace_valid_r <= (state == EVAL) && !dst_bad;
      trace_dst_r   <= g_dst[ptr];
      trace_val_r   <= gate_res;
    end
  end

  assign bus.trace_valid = trace_valid_r;
  assign bus.trace_dst   = trace_dst_r;
  assign bus.trace_val   = trace_val_r;
`endif
endmodule
